// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state and lane encodings for the parking barrier lane
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ENTRY_OPEN = 3'd1,
    EXIT_OPEN  = 3'd2,
    CLOSING    = 3'd3
  } state_t;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_t;

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - phase timer with synchronous clear and terminal-count compare
module gate_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMR_W-1:0] terminal,
  output logic [TMR_W-1:0] count,
  output logic             hit
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TMR_W'(1);
    end
  end

  assign hit = (count == terminal);

endmodule

// File: rtl/gate_scheduler.sv
// rtl/gate_scheduler.sv - round-robin sequencer for the shared entry/exit barrier lane
module gate_scheduler
  import parking_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CLOSE_CYCLES   = 16,
  parameter int TMR_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic       entry_clear,
  input  logic       exit_clear,
  input  logic       parking_full,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       entry_passed,
  output logic       exit_passed,
  output logic       entry_denied,
  output logic       timeout_pulse,
  output logic [2:0] state
);

  localparam logic [TMR_W-1:0] TIMEOUT_TC = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLOSE_TC   = TMR_W'(CLOSE_CYCLES - 1);

  state_t cur_state, nxt_state;
  lane_t  last_grant, nxt_grant;

  logic             entry_ok, exit_ok;
  logic             tmr_hit;
  logic [TMR_W-1:0] tmr_count, tmr_terminal;
  logic             entry_passed_d, exit_passed_d, timeout_d, denied_d;

  assign entry_ok     = entry_req && !parking_full;
  assign exit_ok      = exit_req;
  assign tmr_terminal = (cur_state == CLOSING) ? CLOSE_TC : TIMEOUT_TC;

  gate_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (nxt_state != cur_state),
    .enable   (cur_state != IDLE),
    .terminal (tmr_terminal),
    .count    (tmr_count),
    .hit      (tmr_hit)
  );

  always_comb begin
    nxt_state      = IDLE;
    nxt_grant      = last_grant;
    entry_passed_d = 1'b0;
    exit_passed_d  = 1'b0;
    timeout_d      = 1'b0;
    denied_d       = 1'b0;
    case (cur_state)
      IDLE: begin
        // Entry wins when alone or when exit held the lane last time.
        if (entry_ok && (!exit_ok || last_grant == LANE_EXIT)) begin
          nxt_state = ENTRY_OPEN;
          nxt_grant = LANE_ENTRY;
        end else if (exit_ok) begin
          nxt_state = EXIT_OPEN;
          nxt_grant = LANE_EXIT;
        end else begin
          nxt_state = IDLE;
          denied_d  = entry_req && parking_full;
        end
      end
      ENTRY_OPEN: begin
        if (entry_clear) begin
          nxt_state      = CLOSING;
          entry_passed_d = 1'b1;
        end else if (tmr_hit) begin
          nxt_state = CLOSING;
          timeout_d = 1'b1;
        end else begin
          nxt_state = ENTRY_OPEN;
        end
      end
      EXIT_OPEN: begin
        if (exit_clear) begin
          nxt_state     = CLOSING;
          exit_passed_d = 1'b1;
        end else if (tmr_hit) begin
          nxt_state = CLOSING;
          timeout_d = 1'b1;
        end else begin
          nxt_state = EXIT_OPEN;
        end
      end
      CLOSING: nxt_state = tmr_hit ? IDLE : CLOSING;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state       <= IDLE;
      last_grant      <= LANE_EXIT;
      entry_gate_open <= 1'b0;
      exit_gate_open  <= 1'b0;
      entry_passed    <= 1'b0;
      exit_passed     <= 1'b0;
      entry_denied    <= 1'b0;
      timeout_pulse   <= 1'b0;
    end else begin
      cur_state       <= nxt_state;
      last_grant      <= nxt_grant;
      entry_gate_open <= (nxt_state == ENTRY_OPEN);
      exit_gate_open  <= (nxt_state == EXIT_OPEN);
      entry_passed    <= entry_passed_d;
      exit_passed     <= exit_passed_d;
      entry_denied    <= denied_d;
      timeout_pulse   <= timeout_d;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_gate_scheduler.sv
// tb/tb_gate_scheduler.sv - randomized bench for gate_scheduler against a lane-occupancy model
module tb_gate_scheduler;

  localparam int TIMEOUT_CYCLES = 8;
  localparam int CLOSE_CYCLES   = 2;
  localparam int TMR_W          = 16;
  localparam int SEG_CYCLES     = 200;

  logic       clk = 1'b0;
  logic       reset_n, entry_req, exit_req, entry_clear, exit_clear, parking_full;
  logic       entry_gate_open, exit_gate_open, entry_passed, exit_passed;
  logic       entry_denied, timeout_pulse;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Lane occupancy model: which lane holds the barrier, how long, and closing cycles left.
  int   m_gate;
  int   m_age;
  int   m_close;
  int   m_last;
  logic m_epass, m_xpass, m_to, m_den;

  always #5 clk = ~clk;

  gate_scheduler #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CLOSE_CYCLES   (CLOSE_CYCLES),
    .TMR_W          (TMR_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .entry_req       (entry_req),
    .exit_req        (exit_req),
    .entry_clear     (entry_clear),
    .exit_clear      (exit_clear),
    .parking_full    (parking_full),
    .entry_gate_open (entry_gate_open),
    .exit_gate_open  (exit_gate_open),
    .entry_passed    (entry_passed),
    .exit_passed     (exit_passed),
    .entry_denied    (entry_denied),
    .timeout_pulse   (timeout_pulse),
    .state           (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic e_ok, x_ok, clr;
    m_epass = 1'b0;
    m_xpass = 1'b0;
    m_to    = 1'b0;
    m_den   = 1'b0;
    if (!reset_n) begin
      m_gate  = -1;
      m_age   = 0;
      m_close = 0;
      m_last  = 1;
    end else if (m_close > 0) begin
      m_close--;
    end else if (m_gate < 0) begin
      e_ok = entry_req && !parking_full;
      x_ok = exit_req;
      if (e_ok && x_ok)  m_gate = 1 - m_last;
      else if (e_ok)     m_gate = 0;
      else if (x_ok)     m_gate = 1;
      else               m_den  = entry_req && parking_full;
      if (m_gate >= 0) begin
        m_last = m_gate;
        m_age  = 1;
      end
    end else begin
      clr = (m_gate == 0) ? entry_clear : exit_clear;
      if (clr || m_age == TIMEOUT_CYCLES) begin
        if (clr && m_gate == 0) m_epass = 1'b1;
        else if (clr)           m_xpass = 1'b1;
        else                    m_to    = 1'b1;
        m_gate  = -1;
        m_close = CLOSE_CYCLES;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic compare_all();
    int exp_state;
    exp_state = (m_close > 0) ? 3 : (m_gate < 0) ? 0 : m_gate + 1;
    check("state",           32'(state),           32'(exp_state));
    check("entry_gate_open", 32'(entry_gate_open), 32'(m_gate == 0));
    check("exit_gate_open",  32'(exit_gate_open),  32'(m_gate == 1));
    check("entry_passed",    32'(entry_passed),    32'(m_epass));
    check("exit_passed",     32'(exit_passed),     32'(m_xpass));
    check("timeout_pulse",   32'(timeout_pulse),   32'(m_to));
    check("entry_denied",    32'(entry_denied),    32'(m_den));
    check("gates_exclusive", 32'(entry_gate_open & exit_gate_open), 32'd0);
  endtask

  task automatic drive(input int seg);
    reset_n      = 1'b1;
    exit_clear   = ($urandom_range(0, 3) == 0);
    entry_clear  = ($urandom_range(0, 3) == 0);
    entry_req    = ($urandom_range(0, 1) == 0);
    exit_req     = ($urandom_range(0, 1) == 0);
    parking_full = ($urandom_range(0, 3) == 0);
    case (seg)
      0: begin
        // Lone entry cleared after three open cycles.
        exit_req     = 1'b0;
        parking_full = 1'b0;
        entry_clear  = (m_gate == 0 && m_age == 3);
      end
      1: begin
        entry_req    = 1'b1;
        exit_req     = 1'b1;
        parking_full = 1'b0;
      end
      2: begin
        parking_full = 1'b1;
        entry_req    = 1'b1;
        exit_req     = ($urandom_range(0, 7) == 0);
      end
      3: begin
        entry_clear = 1'b0;
        exit_clear  = 1'b0;
      end
      4: begin
        // Clear lands on the very cycle the timeout would fire.
        entry_clear = (m_gate == 0 && m_age == TIMEOUT_CYCLES);
        exit_clear  = (m_gate == 1 && m_age == TIMEOUT_CYCLES);
      end
      5: begin
        entry_req    = 1'b1;
        exit_req     = 1'b1;
        parking_full = 1'b0;
        entry_clear  = 1'b0;
        reset_n      = !(m_gate == 0 && m_age == 2);
      end
      default: begin
        entry_clear = ($urandom_range(0, 7) == 0);
        exit_clear  = ($urandom_range(0, 7) == 0);
        reset_n     = ($urandom_range(0, 59) != 0);
      end
    endcase
  endtask

  initial begin
    reset_n      = 1'b0;
    entry_req    = 1'b0;
    exit_req     = 1'b0;
    entry_clear  = 1'b0;
    exit_clear   = 1'b0;
    parking_full = 1'b0;
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    compare_all();

    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < SEG_CYCLES; c++) begin
        drive(seg);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
